mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory-access stage of the 5-stage pipeline. Consumes the EX/MEM pipeline register outputs, performs the data-memory load/store and resolves branch/jump redirection.
- Registers results into the MEM/WB pipeline register that feeds write-back.
- Supports a parameterised multi-cycle memory latency. While an access is in progress it raises a stall to the upstream stages.

Parameters:
- size, 32, datapath width in bits.
- DEPTH, 128, data-memory depth in words.
- ADDR_W, 7, word-address width; must equal log2(DEPTH).
- MEM_LAT, 0, extra wait cycles per load/store (0 = single-cycle access).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset, asynchronous, active-low.
- RegWrite_i, Branch_i, Jump_i, MemWrite_i, MemRead_i, MemtoReg_i  in  1 each  control bits from EX/MEM.
- add_branch_i  in  size  branch/jump target.
- Zero_i  in  1  ALU zero flag.
- ALUout_i  in  size  ALU result / byte address.
- RT_data_i  in  size  store data.
- Write_i  in  5  destination register number.
- pc_src_o  out  1  PC redirect select.
- branch_target_o  out  size  redirect target.
- flush_o  out  1  flush IF/ID, ID/EX and EX/MEM.
- stall_o  out  1  hold PC and all upstream pipe registers.
- RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control outputs.
- read_data_o  out  size  MEM/WB loaded word.
- ALUout_o  out  size  MEM/WB ALU result.
- Write_o  out  5  MEM/WB destination register.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All MEM/WB outputs go to 0.
  - FSM goes to IDLE and the wait counter to 0.
  - All DEPTH memory words are cleared to 0.
- Redirect (combinational, never stalled):
  - pc_src_o = (Branch_i & Zero_i) | Jump_i.
  - branch_target_o = add_branch_i.
  - flush_o = pc_src_o.
- Addressing:
  - Word index = ALUout_i[ADDR_W+1:2].
  - Bits [1:0] are ignored (no misalign trap).
  - Higher address bits are truncated, so addresses wrap modulo DEPTH.
- Access condition: acc = MemRead_i | MemWrite_i.
- MEM_LAT=0:
  - Store commits at the posedge of the cycle it is presented.
  - Load: read_data_o is the memory word registered at the same posedge.
  - stall_o is constant 0.
- MEM_LAT>0, FSM states:
  - IDLE:
    - If acc=1, stall_o=1 combinationally and the next state is WAIT with cnt=MEM_LAT-1.
    - If acc=0, stall_o=0.
  - WAIT:
    - If cnt!=0: stall_o=1, cnt decrements each cycle.
    - If cnt==0: stall_o=0. The store commits / load data is captured into MEM/WB at this posedge, and the next state is IDLE.
  - Total occupancy per access is MEM_LAT+1 cycles.
- Pipeline register while stall_o=1: the MEM/WB register loads a bubble (RegWrite_o=0, MemtoReg_o=0). Data outputs hold their previous values.
- Pipeline register when not stalled: it loads RegWrite_i, MemtoReg_i, ALUout_i, Write_i and the read word (read_data_o is 0 when MemRead_i=0).
- Upstream inputs are required to be held stable while stall_o=1.
- MemRead_i=MemWrite_i=1 together: treated as a store. read_data_o returns the pre-write contents.
- Read-after-write:
  - A load in the cycle after a store to the same word returns the new data.
  - A load in the same cycle as the store commit returns the old data (covered by the rule above).
- Reset asserted mid-WAIT: FSM returns to IDLE, the pending store is dropped and stall_o deasserts immediately.
- Flushed bubbles (all controls 0) pass through as NOPs with no memory side effects.

Decomposition:
- Shared package holds: the FSM state encoding (IDLE=1'b0, WAIT=1'b1), WORD_BYTES=4, and the default size/DEPTH constants.
- One natural sub-module: data_memory (array, async-reset clear, write enable, registered/combinational read port). The FSM, redirect logic and MEM/WB register stay in the top module.

Test Plan:
- MEM_LAT=0: store RT_data=0xDEADBEEF at ALUout=0x10, then load 0x10 → read_data_o=0xDEADBEEF, MemtoReg_o=1, Write_o unchanged through, stall_o stays 0.
- Branch_i=1, Zero_i=1, add_branch=0x40 → same cycle pc_src_o=1, flush_o=1, branch_target_o=0x40. With Zero_i=0 → pc_src_o=0. Jump_i=1 alone → pc_src_o=1.
- MEM_LAT=2: load from 0x20 holding 0x5 → stall_o high for exactly 2 cycles. MEM/WB emits RegWrite_o=0 during the stall, then RegWrite_o=1 with read_data_o=0x5 on the third edge.
- Address wrap (DEPTH=128): store 0x11 at ALUout=0x200, then load 0x0 → 0x11. Load at 0x13 → same word as 0x10.
- Reset mid-WAIT with MEM_LAT=3 during a store of 0xA5 to 0x8 → after release, stall_o=0, all outputs 0, and a load of 0x8 → 0.
- MemRead_i=MemWrite_i=1 at 0x4 holding 0x1, storing 0x2 → read_data_o=0x1, and the next load returns 0x2.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared state encoding and default sizing for the MEM stage.
package mem_wb_stage_pkg;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam int WORD_BYTES = 4;
    localparam int SIZE_DEF   = 32;
    localparam int DEPTH_DEF  = 128;

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// mem_wb_stage_data_memory: word-addressed data RAM, cleared on reset, combinational read.
module mem_wb_stage_data_memory
    import mem_wb_stage_pkg::*;
#(
    parameter int size   = SIZE_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [size-1:0]   wdata,
    output logic [size-1:0]   rdata
);

    logic [size-1:0] mem [DEPTH];

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (we)
            mem[addr] <= wdata;

    // Read sees pre-write contents at the commit edge.
    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access, branch/jump redirect and the MEM/WB pipeline register.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int size    = SIZE_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int MEM_LAT = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            RegWrite_i,
    input  logic            Branch_i,
    input  logic            Jump_i,
    input  logic            MemWrite_i,
    input  logic            MemRead_i,
    input  logic            MemtoReg_i,
    input  logic [size-1:0] add_branch_i,
    input  logic            Zero_i,
    input  logic [size-1:0] ALUout_i,
    input  logic [size-1:0] RT_data_i,
    input  logic [4:0]      Write_i,
    output logic            pc_src_o,
    output logic [size-1:0] branch_target_o,
    output logic            flush_o,
    output logic            stall_o,
    output logic            RegWrite_o,
    output logic            MemtoReg_o,
    output logic [size-1:0] read_data_o,
    output logic [size-1:0] ALUout_o,
    output logic [4:0]      Write_o
);

    localparam int OFF   = $clog2(WORD_BYTES);
    localparam int CNT_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic            acc;
    logic            stall;
    logic            we;
    logic [size-1:0] rdata;

    assign acc             = MemRead_i | MemWrite_i;
    assign stall           = (MEM_LAT == 0) ? 1'b0 : (state == IDLE) ? acc : (cnt != '0);
    // An unstalled write is always the final cycle of its access.
    assign we              = MemWrite_i & ~stall;
    assign stall_o         = stall;
    assign pc_src_o        = (Branch_i & Zero_i) | Jump_i;
    assign flush_o         = pc_src_o;
    assign branch_target_o = add_branch_i;

    mem_wb_stage_data_memory #(
        .size  (size),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_dmem (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .we   (we),
        .addr (ALUout_i[ADDR_W+OFF-1:OFF]),
        .wdata(RT_data_i),
        .rdata(rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (MEM_LAT != 0) begin
            if (state == IDLE) begin
                if (acc) begin
                    state <= WAIT;
                    cnt   <= CNT_W'(MEM_LAT - 1);
                end
            end else if (cnt != '0)
                cnt <= cnt - 1'b1;
            else
                state <= IDLE;
        end

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            RegWrite_o  <= 1'b0;
            MemtoReg_o  <= 1'b0;
            read_data_o <= '0;
            ALUout_o    <= '0;
            Write_o     <= '0;
        end else if (stall) begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
        end else begin
            RegWrite_o  <= RegWrite_i;
            MemtoReg_o  <= MemtoReg_i;
            read_data_o <= MemRead_i ? rdata : '0;
            ALUout_o    <= ALUout_i;
            Write_o     <= Write_i;
        end

endmodule
